shader_data_buffer: RTL
=======================

SHADER_DATA_BUFFER -- requirements
Module: shader_data_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per stored word.
REQ-002 SHALL have parameter LANES, default 4, words per packed write (power of 2, 1..8).
REQ-003 SHALL have parameter DEPTH, default 4096, words of storage (power of 2, multiple of LANES).
REQ-004 SHALL have parameter WRAP, default 0; 0 = stop when full, 1 = circular overwrite.
REQ-005 SHALL derive localparam AW = log2(DEPTH).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 clr  input  1  synchronous active-high clear of pointer, count and flags (per-shader restart).
REQ-009 wr_valid  input  1  packed write request.
REQ-010 wr_ready  output  1  buffer can accept a packed write this cycle.
REQ-011 wr_data  input  LANES*DATA_WIDTH  lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 wr_mask  input  LANES  per-lane write enable; masked lanes leave memory unchanged.
REQ-013 rd_en  input  1  read request.
REQ-014 rd_addr  input  AW  word address.
REQ-015 rd_data  output  DATA_WIDTH  registered read data.
REQ-016 rd_valid  output  1  rd_data holds the result of the previous cycle's rd_en.
REQ-017 wr_count  output  AW+1  words written since last clear, saturating at DEPTH.
REQ-018 full  output  1  wr_count == DEPTH.
REQ-019 wrapped  output  1  sticky: at least one overwrite occurred (WRAP=1 only).

Function
REQ-020 SHALL accept a write when wr_valid && wr_ready && !clr (a "write beat").
REQ-021 On a write beat, lane i SHALL be stored at wr_ptr+i when wr_mask[i]=1.
REQ-022 Each write beat SHALL advance wr_ptr by LANES regardless of wr_mask (mask 0 = lane skipped, slot reserved).
REQ-023 wr_ptr SHALL be AW bits wide and wrap modulo DEPTH; a beat never straddles the wrap point.
REQ-024 WRAP=0: wr_ready SHALL equal !full; beats are never accepted while full.
REQ-025 WRAP=1: wr_ready SHALL be constant 1; a beat accepted while full SHALL overwrite oldest slots and set wrapped.
REQ-026 wr_count SHALL increase by LANES per beat and saturate at DEPTH.
REQ-027 Read SHALL have latency 1: rd_en at edge N gives rd_data/rd_valid valid after edge N+1.
REQ-028 rd_valid SHALL be 1 exactly one cycle per rd_en cycle; back-to-back reads SHALL sustain one word per cycle.
REQ-029 When rd_en=0, rd_data SHALL hold its last value (no tri-state).
REQ-030 Read and write to the same address in one cycle SHALL return the old (pre-write) data.
REQ-031 clr SHALL take priority over a simultaneous write beat; the beat is dropped and memory is unchanged.
REQ-032 clr SHALL not alter memory contents nor an in-flight read result.
REQ-033 Memory array SHALL be inferable as block RAM; it is not cleared by reset or clr.

Reset
REQ-034 While rstn=0: wr_ptr=0, wr_count=0, full=0, wrapped=0, rd_valid=0, rd_data=0.
REQ-035 wr_ready after reset SHALL be 1 in both WRAP modes.
REQ-036 Reset asserted mid-operation SHALL discard any in-flight read (rd_valid=0 next cycle after release).
REQ-037 Memory contents after reset are undefined; reads before write return unspecified data with rd_valid=1.

Verification
REQ-038 Defaults: beat wr_data={32'h4,32'h3,32'h2,32'h1}, mask 4'hF; read addr 0..3 -> rd_data 1,2,3,4 one cycle after each rd_en; wr_count=4.
REQ-039 Mask 4'b0101 beat of {D3,D2,D1,D0} over prior zeros -> addr0=D0, addr1=0, addr2=D2, addr3=0; wr_count=4.
REQ-040 WRAP=0, DEPTH=16: 4 beats -> full=1, wr_ready=0; 5th beat ignored, wr_count stays 16, contents unchanged.
REQ-041 WRAP=1, DEPTH=16: 5 beats -> addr0..3 hold beat 5, wrapped=1, wr_count=16, wr_ready=1.
REQ-042 clr asserted with wr_valid after 2 beats -> wr_count=0, wr_ptr=0, next beat lands at addr 0; earlier data at addr 4..7 still readable.
REQ-043 Same-cycle read/write addr 0 (old 5, new 9) -> rd_data=5; read next cycle -> 9; rstn pulse mid-read -> rd_valid=0, rd_data=0.

Source files
------------

// File: rtl/shader_data_buffer.sv
// Per-shader output buffer: packed multi-lane writes into a banked word store,
// single-word registered reads, optional circular overwrite.
module shader_data_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 4096,
    parameter int WRAP       = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [LANES*DATA_WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]            wr_mask,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic [AW:0]                 wr_count,
    output logic                        full,
    output logic                        wrapped
);

    localparam int LB   = $clog2(LANES);
    localparam int SW   = (LB > 0) ? LB : 1;
    localparam int ROWS = DEPTH / LANES;
    localparam int RW   = (AW - LB > 0) ? AW - LB : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LANES_C = (AW + 1)'(LANES);

    logic [AW-1:0]               wrPtr;
    logic [AW:0]                 wrCount;
    logic                        wrappedQ;
    logic                        beat;
    logic [RW-1:0]               wrRow;
    logic [RW-1:0]               rdRow;
    logic [SW-1:0]               rdLane;
    logic [SW-1:0]               rdLaneQ;
    logic                        rdZero;
    logic [LANES*DATA_WIDTH-1:0] laneQ;

    // Handshake: a beat transfers on a rising edge where wr_valid && wr_ready
    // and clr is low; wr_ready never depends on wr_valid, and clr drops a beat.
    assign full     = (wrCount == DEPTH_C);
    assign wr_ready = (WRAP != 0) ? 1'b1 : !full;
    assign beat     = wr_valid && wr_ready && !clr;
    assign wr_count = wrCount;
    assign wrapped  = wrappedQ;

    // wrPtr is always a multiple of LANES, so lane i of a beat maps to bank i.
    assign wrRow  = RW'(wrPtr >> LB);
    assign rdRow  = RW'(rd_addr >> LB);
    assign rdLane = SW'(32'(rd_addr) % LANES);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr    <= '0;
            wrCount  <= '0;
            wrappedQ <= 1'b0;
        end else if (clr) begin
            wrPtr    <= '0;
            wrCount  <= '0;
            wrappedQ <= 1'b0;
        end else if (beat) begin
            wrPtr <= wrPtr + AW'(LANES);
            if (full) begin
                wrappedQ <= 1'b1;
            end else begin
                wrCount <= wrCount + LANES_C;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gBank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] q;

        // Read samples the pre-write contents on a same-address collision.
        always_ff @(posedge clk) begin
            if (beat && wr_mask[g]) begin
                mem[wrRow] <= wr_data[g*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_en) begin
                q <= mem[rdRow];
            end
        end

        assign laneQ[g*DATA_WIDTH +: DATA_WIDTH] = q;
    end

    // rdZero forces the reset value of rd_data until the first read lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rdLaneQ  <= '0;
            rdZero   <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rdLaneQ <= rdLane;
                rdZero  <= 1'b0;
            end
        end
    end

    assign rd_data = rdZero ? '0 : laneQ[rdLaneQ*DATA_WIDTH +: DATA_WIDTH];

endmodule
